// File: rtl/queue_cnt_pkg.sv
// Shared types and parameter checks for queue_occupancy_counter.
// Optional input synchroniser is enabled with the QUEUE_CNT_SYNC_EN macro.
package queue_cnt_pkg;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_INC  = 2'b01,
    EV_DEC  = 2'b10,
    EV_BOTH = 2'b11
  } edge_ev_e;

  function automatic logic params_legal(input int width, input int max_count,
                                        input int almost_full);
    logic ok;
    ok = 1'b1;
    if ((width < 1) || (width > 16)) begin
      ok = 1'b0;
    end else if ((max_count < 1) || (max_count > ((2 ** width) - 1))) begin
      ok = 1'b0;
    end else if ((almost_full < 1) || (almost_full > max_count)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sensor_edge_detect.sv
// Sample/history registers and falling-edge detect for one active-low sensor.
// With QUEUE_CNT_SYNC_EN defined, two synchroniser flops precede the sample stage.
module sensor_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sense_n,
  output logic fall
);

  logic prime_q, prime_d;
  logic s_q, s_d;
  logic p_q, p_d;
  logic stage_in;

`ifdef QUEUE_CNT_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d   = {sync_q[0], sense_n};
    stage_in = sync_q[1];
    if (prime_q) begin
      sync_d = {sense_n, sense_n};
    end else begin
      sync_d = {sync_q[0], sense_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  always_comb begin
    stage_in = sense_n;
  end
`endif

  // The first edge after reset seeds every stage with the live level, so a
  // sensor already held low at reset release never looks like a new entry.
  always_comb begin
    prime_d = 1'b0;
    s_d     = stage_in;
    p_d     = s_q;
    if (prime_q) begin
      s_d = sense_n;
      p_d = sense_n;
    end else begin
      s_d = stage_in;
      p_d = s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q <= 1'b1;
      s_q     <= 1'b1;
      p_q     <= 1'b1;
    end else begin
      prime_q <= prime_d;
      s_q     <= s_d;
      p_q     <= p_d;
    end
  end

  assign fall = p_q & ~s_q;

endmodule

// File: rtl/queue_occupancy_counter.sv
// Saturating queue occupancy counter driven by entry/exit sensor falling edges.
// Define QUEUE_CNT_SYNC_EN to add a two-flop synchroniser on Up and Down.
module queue_occupancy_counter
  import queue_cnt_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int MAX_COUNT   = 7,
  parameter int ALMOST_FULL = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Count,
  output logic             FullFlag,
  output logic             EmptyFlag,
  output logic             AlmostFullFlag,
  output logic             Overflow,
  output logic             Underflow
);

  generate
    if (!params_legal(WIDTH, MAX_COUNT, ALMOST_FULL)) begin : g_bad_params
      $error("queue_occupancy_counter: illegal WIDTH/MAX_COUNT/ALMOST_FULL");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] AF_C  = WIDTH'(ALMOST_FULL);

  logic     inc_s, dec_s;
  edge_ev_e ev_s;

  logic [WIDTH-1:0] count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  sensor_edge_detect u_up_det (
    .clk     (Clk),
    .rst     (Reset),
    .sense_n (Up),
    .fall    (inc_s)
  );

  sensor_edge_detect u_dn_det (
    .clk     (Clk),
    .rst     (Reset),
    .sense_n (Down),
    .fall    (dec_s)
  );

  // Simultaneous entry and exit cancel, even at full or empty.
  always_comb begin
    ev_s    = edge_ev_e'({dec_s, inc_s});
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    case (ev_s)
      EV_INC: begin
        if (count_q < MAX_C) begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          ovf_d = 1'b1;
        end
      end
      EV_DEC: begin
        if (count_q > {WIDTH{1'b0}}) begin
          count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          udf_d = 1'b1;
        end
      end
      EV_BOTH: count_d = count_q;
      EV_NONE: count_d = count_q;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == MAX_C);
    empty_d = (count_d == {WIDTH{1'b0}});
    afull_d = (count_d >= AF_C);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= {WIDTH{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign Count          = count_q;
  assign FullFlag       = full_q;
  assign EmptyFlag      = empty_q;
  assign AlmostFullFlag = afull_q;
  assign Overflow       = ovf_q;
  assign Underflow      = udf_q;

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Self-checking bench for queue_occupancy_counter: directed scenarios plus
// randomized sensor traffic checked every cycle against a behavioural model.
module tb_queue_occupancy_counter;

`ifdef QUEUE_CNT_SYNC_EN
  localparam int W = 4, MAXC = 12, AF = 10, D = 2;
`else
  localparam int W = 3, MAXC = 7, AF = 6, D = 0;
`endif

  logic Clk = 1'b0;
  logic Reset, Up, Down;
  logic [W-1:0] Count;
  logic FullFlag, EmptyFlag, AlmostFullFlag, Overflow, Underflow;

  queue_occupancy_counter #(.WIDTH(W), .MAX_COUNT(MAXC), .ALMOST_FULL(AF)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Up             (Up),
    .Down           (Down),
    .Count          (Count),
    .FullFlag       (FullFlag),
    .EmptyFlag      (EmptyFlag),
    .AlmostFullFlag (AlmostFullFlag),
    .Overflow       (Overflow),
    .Underflow      (Underflow)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ov_seen = 0;
  int uf_seen = 0;

  // Behavioural model: sampled sensor levels (index 0 = newest) and occupancy.
  bit up_h[0:5];
  bit dn_h[0:5];
  bit m_prime;
  int m_count;
  bit m_ovf, m_udf;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_prime = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_h[i] = 1'b1;
      dn_h[i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit inc, dec;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (Reset) begin
      model_reset();
    end else if (m_prime) begin
      for (int i = 0; i < 6; i++) begin
        up_h[i] = Up;
        dn_h[i] = Down;
      end
      m_prime = 1'b0;
    end else begin
      for (int i = 5; i > 0; i--) begin
        up_h[i] = up_h[i-1];
        dn_h[i] = dn_h[i-1];
      end
      up_h[0] = Up;
      dn_h[0] = Down;
      inc = up_h[2+D] && !up_h[1+D];
      dec = dn_h[2+D] && !dn_h[1+D];
      if (inc && !dec) begin
        if (m_count < MAXC) m_count++;
        else m_ovf = 1'b1;
      end else if (dec && !inc) begin
        if (m_count > 0) m_count--;
        else m_udf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("count", int'(Count), m_count);
    chk("full", int'(FullFlag), int'(m_count == MAXC));
    chk("empty", int'(EmptyFlag), int'(m_count == 0));
    chk("almost_full", int'(AlmostFullFlag), int'(m_count >= AF));
    chk("overflow", int'(Overflow), int'(m_ovf));
    chk("underflow", int'(Underflow), int'(m_udf));
    ov_seen += int'(Overflow);
    uf_seen += int'(Underflow);
  endtask

  task automatic tick(input logic up, input logic dn);
    Up = up;
    Down = dn;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic settle();
    repeat (D + 3) tick(1'b1, 1'b1);
  endtask

  task automatic pulse_up();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
  endtask

  initial begin
    Up = 1'b1;
    Down = 1'b1;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("reset_count", int'(Count), 0);
    chk("reset_empty", int'(EmptyFlag), 1);
    chk("reset_full", int'(FullFlag), 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    Reset = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    // Three entries
    for (int k = 1; k <= 3; k++) begin
      pulse_up();
      settle();
      chk("up_count", int'(Count), k);
      chk("model_up_count", m_count, k);
    end

    // Fill past capacity: exactly one rejected entry
    ov_seen = 0;
    for (int k = 4; k <= MAXC + 1; k++) begin
      pulse_up();
      settle();
    end
    chk("sat_count", int'(Count), MAXC);
    chk("sat_full", int'(FullFlag), 1);
    chk("sat_almost_full", int'(AlmostFullFlag), 1);
    chk("overflow_pulses", ov_seen, 1);

    // Simultaneous entry and exit at full
    ov_seen = 0;
    uf_seen = 0;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    settle();
    chk("both_count", int'(Count), MAXC);
    chk("both_no_overflow", ov_seen, 0);
    chk("both_no_underflow", uf_seen, 0);

    // Asynchronous reset mid-pulse
    Up = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_count", int'(Count), 0);
    chk("async_reset_empty", int'(EmptyFlag), 1);
    tick(1'b1, 1'b1);
    Reset = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    // Exit at empty
    uf_seen = 0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    settle();
    chk("underflow_count", int'(Count), 0);
    chk("underflow_pulses", uf_seen, 1);
    chk("underflow_empty", int'(EmptyFlag), 1);

    // Held-low level counts once
    repeat (10) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    settle();
    chk("held_low_count", int'(Count), 1);
    chk("model_held_low_count", m_count, 1);

    // Up held low across reset release
    repeat (3) tick(1'b0, 1'b1);
    Reset = 1'b1;
    repeat (2) tick(1'b0, 1'b1);
    Reset = 1'b0;
    repeat (5) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    settle();
    chk("low_at_release_count", int'(Count), 0);
    chk("model_low_at_release", m_count, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic nu, nd;
      nu = ($urandom_range(0, 9) < 3) ? ~Up : Up;
      nd = ($urandom_range(0, 9) < 3) ? ~Down : Down;
      Reset = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
      tick(nu, nd);
    end
    Reset = 1'b0;
    settle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
